// File: rtl/mem_pkg.sv
// Shared definitions for the slow-memory responder: FSM encoding, alignment
// constant and the index-width helper used to size the word array.
package mem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_WAIT = 2'b01,
        ST_RESP = 2'b10
    } state_t;

    localparam logic [1:0] ALIGN_MASK = 2'b00;

    // Smallest w with 2**w >= depth; exact log2 for power-of-two sizes.
    function automatic int idx_width(input int depth);
        int w;
        w = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'd1 << i) < depth) begin
                w = i + 1;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/mem_array.sv
// DEPTH x 32 word storage: synchronous write, registered read port that can be
// forced to zero so error responses never leak stale array contents.
module mem_array
    import mem_pkg::*;
#(
    parameter int DEPTH = 256,
    parameter int IW    = idx_width(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic          re,
    input  logic          clr,
    input  logic [IW-1:0] idx,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem_r [DEPTH];

    // Array storage: contents survive reset on purpose.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[idx] <= wdata;
        end
    end

    // Read-data register: holds between responses, zeroed on error.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata <= 32'd0;
        end else if (clr) begin
            rdata <= 32'd0;
        end else if (re) begin
            rdata <= mem_r[idx];
        end else begin
            rdata <= rdata;
        end
    end

endmodule

// File: rtl/mem_responder.sv
// Multi-cycle memory responder: accepts one request, waits LATENCY cycles,
// then strobes Ready with read data or an error flag.
module mem_responder
    import mem_pkg::*;
#(
    parameter int DEPTH   = 256,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        Req,
    input  logic        MemRd,
    input  logic        MemWr,
    input  logic [31:0] Addr,
    input  logic [31:0] W_data,
    output logic [31:0] R_data,
    output logic        Ready,
    output logic        Busy,
    output logic        Err
);

    localparam int IW = idx_width(DEPTH);
    localparam int CW = idx_width(LATENCY) + 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(LATENCY - 1);

    state_t         state_r;
    state_t         next_s;
    logic [CW-1:0]  cnt_r;
    logic           op_wr_r;
    logic [31:0]    addr_r;
    logic [31:0]    wdata_r;
    logic           ready_r;
    logic           busy_r;
    logic           err_r;

    logic           qual_ok_s;
    logic           addr_err_s;
    logic           we_s;
    logic           re_s;
    logic           clr_s;
    logic           err_next_s;

    assign qual_ok_s  = MemRd ^ MemWr;
    // Any set bit above the index field is out of range: no aliasing.
    assign addr_err_s = (addr_r[1:0] != ALIGN_MASK) ||
                        ((addr_r >> (IW + 2)) != 32'd0);

    // Next-state and array-access decode.
    always_comb begin
        next_s     = state_r;
        we_s       = 1'b0;
        re_s       = 1'b0;
        clr_s      = 1'b0;
        err_next_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (Req) begin
                    if (qual_ok_s) begin
                        next_s = ST_WAIT;
                    end else begin
                        next_s     = ST_RESP;
                        clr_s      = 1'b1;
                        err_next_s = 1'b1;
                    end
                end else begin
                    next_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (cnt_r == {CW{1'b0}}) begin
                    next_s = ST_RESP;
                    if (addr_err_s) begin
                        clr_s      = 1'b1;
                        err_next_s = 1'b1;
                    end else if (op_wr_r) begin
                        we_s = 1'b1;
                    end else begin
                        re_s = 1'b1;
                    end
                end else begin
                    next_s = ST_WAIT;
                end
            end
            ST_RESP: begin
                next_s = ST_IDLE;
            end
            default: begin
                next_s = ST_IDLE;
            end
        endcase
    end

    // State, wait counter and request latches.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
            cnt_r   <= {CW{1'b0}};
            op_wr_r <= 1'b0;
            addr_r  <= 32'd0;
            wdata_r <= 32'd0;
        end else begin
            state_r <= next_s;
            if (state_r == ST_IDLE && Req && qual_ok_s) begin
                cnt_r   <= CNT_LOAD;
                op_wr_r <= MemWr;
                addr_r  <= Addr;
                wdata_r <= W_data;
            end else if (state_r == ST_WAIT && cnt_r != {CW{1'b0}}) begin
                cnt_r <= cnt_r - CW'(1);
            end else begin
                cnt_r <= cnt_r;
            end
        end
    end

    // Registered status outputs derived from the upcoming state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ready_r <= 1'b0;
            busy_r  <= 1'b0;
            err_r   <= 1'b0;
        end else begin
            ready_r <= (next_s == ST_RESP);
            busy_r  <= (next_s != ST_IDLE);
            err_r   <= err_next_s;
        end
    end

    mem_array #(
        .DEPTH (DEPTH),
        .IW    (IW)
    ) u_array (
        .clk   (clk),
        .rst   (rst),
        .we    (we_s),
        .re    (re_s),
        .clr   (clr_s),
        .idx   (addr_r[IW+1:2]),
        .wdata (wdata_r),
        .rdata (R_data)
    );

    assign Ready = ready_r;
    assign Busy  = busy_r;
    assign Err   = err_r;

endmodule
